// File: rtl/universal_shift_transmitter.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out one bit per bit_en strobe. Define UNIV_SHIFT_TX_PARITY_EN to append an even-parity bit.
module universal_shift_transmitter #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             bit_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef UNIV_SHIFT_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UNIV_SHIFT_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign load_ready   = (state_q == IDLE);
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            cnt_q          <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef UNIV_SHIFT_TX_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            cnt_q          <= cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef UNIV_SHIFT_TX_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    // The shift register holds only the bits not yet on serial_out.
    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        cnt_d          = cnt_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
`ifdef UNIV_SHIFT_TX_PARITY_EN
        parity_d       = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d        = SHIFT;
                    cnt_d          = '0;
                    serial_valid_d = 1'b1;
                    busy_d         = 1'b1;
                    if (MSB_FIRST != 0) begin
                        serial_out_d = load_data[WIDTH-1];
                        shreg_d      = load_data << 1;
                    end else begin
                        serial_out_d = load_data[0];
                        shreg_d      = load_data >> 1;
                    end
`ifdef UNIV_SHIFT_TX_PARITY_EN
                    parity_d = ^load_data;
`endif
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt_q == LAST) begin
`ifdef UNIV_SHIFT_TX_PARITY_EN
                        state_d      = PARITY;
                        serial_out_d = parity_q;
`else
                        state_d        = IDLE;
                        serial_out_d   = 1'b0;
                        serial_valid_d = 1'b0;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (MSB_FIRST != 0) begin
                            serial_out_d = shreg_q[WIDTH-1];
                            shreg_d      = shreg_q << 1;
                        end else begin
                            serial_out_d = shreg_q[0];
                            shreg_d      = shreg_q >> 1;
                        end
                    end
                end
            end
`ifdef UNIV_SHIFT_TX_PARITY_EN
            PARITY: begin
                if (bit_en) begin
                    state_d        = IDLE;
                    serial_out_d   = 1'b0;
                    serial_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_universal_shift_transmitter.sv
// Bench for universal_shift_transmitter: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a bit-queue model of the frame.
module tb_universal_shift_transmitter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         bit_en;

    logic rdy0, so0, sv0, busy0, done0;
    logic rdy1, so1, sv1, busy1, done1;

    int errors = 0;
    int checks = 0;

    bit m_active;
    bit m_done;
    bit m_q0[$];
    bit m_q1[$];

    always #5 clk = ~clk;

    universal_shift_transmitter #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy0), .bit_en(bit_en), .serial_out(so0), .serial_valid(sv0),
        .busy(busy0), .done(done0)
    );

    universal_shift_transmitter #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy1), .bit_en(bit_en), .serial_out(so1), .serial_valid(sv1),
        .busy(busy1), .done(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Frame model: the queue holds the bits still to be sent, the front one being on the wire.
    task automatic model_step(input bit lv, input logic [W-1:0] ld, input bit be, input bit rst);
        bit nd;
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_q0.delete();
            m_q1.delete();
        end else begin
            nd = 1'b0;
            if (m_active) begin
                if (be) begin
                    void'(m_q0.pop_front());
                    void'(m_q1.pop_front());
                    if (m_q0.size() == 0) begin
                        m_active = 1'b0;
                        nd = 1'b1;
                    end
                end
            end else if (lv) begin
                m_q0.delete();
                m_q1.delete();
                for (int i = 0; i < W; i++) begin
                    m_q0.push_back(ld[i]);
                    m_q1.push_back(ld[W-1-i]);
                end
`ifdef UNIV_SHIFT_TX_PARITY_EN
                m_q0.push_back(^ld);
                m_q1.push_back(^ld);
`endif
                m_active = 1'b1;
            end
            m_done = nd;
        end
    endtask

    task automatic check_all();
        bit e0, e1;
        e0 = m_active ? m_q0[0] : 1'b0;
        e1 = m_active ? m_q1[0] : 1'b0;
        check_eq("lsb.serial_out",   32'(so0),   32'(e0));
        check_eq("lsb.serial_valid", 32'(sv0),   32'(m_active));
        check_eq("lsb.busy",         32'(busy0), 32'(m_active));
        check_eq("lsb.done",         32'(done0), 32'(m_done));
        check_eq("lsb.load_ready",   32'(rdy0),  32'(!m_active));
        check_eq("msb.serial_out",   32'(so1),   32'(e1));
        check_eq("msb.serial_valid", 32'(sv1),   32'(m_active));
        check_eq("msb.busy",         32'(busy1), 32'(m_active));
        check_eq("msb.done",         32'(done1), 32'(m_done));
        check_eq("msb.load_ready",   32'(rdy1),  32'(!m_active));
    endtask

    task automatic cyc(input bit lv, input logic [W-1:0] ld, input bit be);
        load_valid = lv;
        load_data  = ld;
        bit_en     = be;
        @(posedge clk);
        model_step(lv, ld, be, reset);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        bit_en     = 1'b0;
        model_step(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 4'b1111, 1'b1);
        cyc(1'b0, '0, 1'b0);
        reset = 1'b0;

        // Plain frame with bit_en tied high, then idle
        cyc(1'b1, 4'b1011, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 4'b0000, 1'b1);

        // bit_en every third cycle
        cyc(1'b1, 4'b0110, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 4'b0000, (i % 3) == 2);

        // load_valid pulses mid-frame must be ignored
        cyc(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < 10; i++) cyc(i[0], 4'b1111, (i % 2) == 1);
        cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);

        // Reset after two bits; asynchronous clear checked before the next edge
        cyc(1'b1, 4'b1011, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("async_reset.serial_valid", 32'(sv0), 32'd0);
        check_eq("async_reset.busy",         32'(busy1), 32'd0);
        cyc(1'b0, 4'b0000, 1'b1);
        reset = 1'b0;
        cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0001, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 4'b0000, 1'b1);

        // Back-to-back: producer holds load_valid continuously
        for (int i = 0; i < 20; i++) cyc(1'b1, W'($urandom), 1'b1);

        // Randomized traffic with varying bit-rate density
        for (int i = 0; i < 600; i++) begin
            int dens;
            dens = (i / 150) % 4;
            cyc($urandom_range(0, 3) == 0, W'($urandom),
                (dens == 0) ? 1'b1 : ($urandom_range(0, dens) == 0));
        end

        // Occasional random resets
        for (int i = 0; i < 200; i++) begin
            reset = ($urandom_range(0, 40) == 0);
            cyc($urandom_range(0, 1) == 0, W'($urandom), $urandom_range(0, 1) == 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'b0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
